pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_if.sv | 35 +++
 rtl/pixel_writer.sv | 187 ++++++++++++++++++
 tb/tb_pixel_writer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_writer_if.sv
// Pixel writer bus bundle: the pixel stream from the line drawer plus the framebuffer write port.
//
// Signals:
//   px_valid, px_ready        pixel-stream handshake (line drawer -> writer)
//   px_x, px_y [10:0]         pixel coordinates
//   px_color, px_last         pixel value and end-of-line marker
//   mem_we, mem_addr [18:0]   framebuffer write strobe and linear address
//   mem_data, mem_ack         write data and write acknowledge from the framebuffer
//
// Modports:
//   slave   the pixel writer itself (sinks pixels, drives the framebuffer port)
//   master  the environment (line drawer + framebuffer)
interface pixel_writer_if;
    logic        px_valid;
    logic        px_ready;
    logic [10:0] px_x;
    logic [10:0] px_y;
    logic        px_color;
    logic        px_last;

    logic        mem_we;
    logic [18:0] mem_addr;
    logic        mem_data;
    logic        mem_ack;

    modport slave (
        input  px_valid, px_x, px_y, px_color, px_last, mem_ack,
        output px_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output px_valid, px_x, px_y, px_color, px_last, mem_ack,
        input  px_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/pixel_writer.sv
// Pixel writer: buffers pixels from a line drawer in a small FIFO and writes each visible pixel
// into a 1-bit-per-pixel framebuffer (address = y*WIDTH + x). Off-screen pixels are dropped
// without a memory write.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   bus         pixel_writer_if.slave: pixel stream in, framebuffer write port out
//   line_done   one-cycle pulse after the last pixel of a line has been retired
//   busy        FIFO non-empty or a pixel in flight
//   clip_count  (only with PIXEL_WRITER_CLIP_COUNT_EN) saturating count of clipped pixels
//
// Optional feature macro: PIXEL_WRITER_CLIP_COUNT_EN
module pixel_writer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned DEPTH  = 8
) (
    input  logic          clk,
    input  logic          reset,
    pixel_writer_if.slave bus,
    output logic          line_done,
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
    output logic [15:0]   clip_count,
`endif
    output logic          busy
);

    localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam logic [18:0] WidthW = 19'(WIDTH);

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        color;
        logic        last;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StAddr, StWrite} state_e;

    entry_t            fifo_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              px_ready_q, px_ready_d;

    state_e            state_q, state_d;
    entry_t            cur_q, cur_d;
    logic              mem_we_q, mem_we_d;
    logic [18:0]       mem_addr_q, mem_addr_d;
    logic              mem_data_q, mem_data_d;
    logic              line_done_q, line_done_d;

    entry_t            push_entry;
    entry_t            head;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              head_clipped;

    assign push_entry   = '{x: bus.px_x, y: bus.px_y, color: bus.px_color, last: bus.px_last};
    assign push         = bus.px_valid && px_ready_q;
    assign head         = fifo_q[rd_ptr_q];
    assign fifo_empty   = (count_q == '0);
    assign head_clipped = (32'(head.x) >= WIDTH) || (32'(head.y) >= HEIGHT);

    // FIFO storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        line_done_d = 1'b0;
        pop         = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    if (head_clipped) begin
                        // Retired on the spot: no memory cycle for off-screen pixels.
                        line_done_d = head.last;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                mem_addr_d = ({8'b0, cur_q.y} * WidthW) + {8'b0, cur_q.x};
                mem_data_d = cur_q.color;
                mem_we_d   = 1'b1;
                state_d    = StWrite;
            end
            StWrite: begin
                if (bus.mem_ack) begin
                    mem_we_d    = 1'b0;
                    line_done_d = cur_q.last;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Registered ready reflects the occupancy after this edge, so a push can never overflow.
        px_ready_d = (32'(count_d) < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            px_ready_q  <= 1'b1;
            state_q     <= StIdle;
            cur_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            px_ready_q  <= px_ready_d;
            state_q     <= state_d;
            cur_q       <= cur_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            line_done_q <= line_done_d;
        end
    end

`ifdef PIXEL_WRITER_CLIP_COUNT_EN
    logic [15:0] clip_count_q, clip_count_d;
    logic        clip_retire;

    assign clip_retire = (state_q == StIdle) && !fifo_empty && head_clipped;

    always_comb begin
        clip_count_d = clip_count_q;
        if (clip_retire && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;
`endif

    assign bus.px_ready = px_ready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign line_done    = line_done_q;
    assign busy         = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: directed pixel pushes; the expected framebuffer writes are queued
// at push time and a negedge monitor pops and compares them as writes are acknowledged.
module tb_pixel_writer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic line_done;
    logic busy;
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    pixel_writer_if bus ();

    pixel_writer #(
        .WIDTH (640),
        .HEIGHT(480),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .line_done (line_done),
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
        .clip_count(clip_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0] addr;
        logic        data;
    } wr_t;

    wr_t    exp_q[$];
    longint write_cyc[$];
    int     errors  = 0;
    int     checks  = 0;
    int     n_writes = 0;
    int     n_ld     = 0;
    int     n_acc    = 0;
    longint cyc      = 0;
    longint acc_cyc  = 0;
    longint ld_cyc   = 0;
    longint we_rise_cyc = 0;
    logic   we_prev  = 1'b0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: a write retires on the next edge whenever mem_we and mem_ack are both high.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.mem_we && !we_prev) we_rise_cyc = cyc;
                if (bus.mem_we && bus.mem_ack) begin
                    n_writes++;
                    write_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %0d with nothing expected",
                                 bus.mem_addr, bus.mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", longint'(bus.mem_addr), longint'(e.addr));
                        check("write_data", longint'(bus.mem_data), longint'(e.data));
                    end
                end
                if (line_done) begin
                    n_ld++;
                    ld_cyc = cyc;
                end
            end
            we_prev = bus.mem_we;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_px(input int x, input int y, input bit c, input bit l);
        int n = 0;
        bus.px_valid = 1'b1;
        bus.px_x     = 11'(x);
        bus.px_y     = 11'(y);
        bus.px_color = c;
        bus.px_last  = l;
        while (!bus.px_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.px_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: px_ready got 0 expected 1 for pixel (%0d,%0d)", x, y);
            bus.px_valid = 1'b0;
            return;
        end
        if (x < 640 && y < 480) exp_q.push_back('{addr: 19'(y * 640 + x), data: c});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        n_acc++;
        bus.px_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: busy got %0b, pending writes %0d expected 0",
                     busy, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Holds px_valid high during reset to show it is ignored.
    task automatic do_reset();
        reset        = 1'b1;
        bus.px_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.px_valid = 1'b0;
        exp_q.delete();
    endtask

    int ys[12] = '{1, 1, 2, 2, 2, 3, 3, 4, 4, 4, 5, 5};

    initial begin
        int w0, l0, a0, wc0, n;
        bus.px_valid = 1'b0;
        bus.px_x     = '0;
        bus.px_y     = '0;
        bus.px_color = 1'b0;
        bus.px_last  = 1'b0;
        bus.mem_ack  = 1'b1;

        // Reset state
        do_reset();
        check("rst_px_ready", longint'(bus.px_ready), 1);
        check("rst_mem_we", longint'(bus.mem_we), 0);
        check("rst_mem_addr", longint'(bus.mem_addr), 0);
        check("rst_mem_data", longint'(bus.mem_data), 0);
        check("rst_line_done", longint'(line_done), 0);
        check("rst_busy", longint'(busy), 0);
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
        check("rst_clip_count", longint'(clip_count), 0);
`endif

        // Single pixel: (3,2) -> 2*640+3 = 1283
        w0 = n_writes;
        l0 = n_ld;
        push_px(3, 2, 1'b1, 1'b1);
        drain();
        check("t1_writes", n_writes - w0, 1);
        check("t1_we_latency", we_rise_cyc - acc_cyc, 2);
        check("t1_line_done_count", n_ld - l0, 1);
        check("t1_line_done_latency", ld_cyc - acc_cyc, 3);
        check("t1_busy_after", longint'(busy), 0);

        // Back-pressure: 8 in the FIFO plus the one held by the stalled write
        w0 = n_writes;
        a0 = n_acc;
        bus.mem_ack = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) push_px(i, 10 + i, bit'(i % 2), i == 9);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                check("t2_accepts_while_stalled", n_acc - a0, 9);
                check("t2_px_ready_low", longint'(bus.px_ready), 0);
                check("t2_mem_we_held", longint'(bus.mem_we), 1);
                check("t2_mem_addr_held", longint'(bus.mem_addr), 6400);
                check("t2_no_writes_stalled", n_writes - w0, 0);
                bus.mem_ack = 1'b1;
            end
        join
        drain();
        check("t2_writes", n_writes - w0, 10);

        // Clipping: both pixels off-screen
        do_reset();
        w0 = n_writes;
        l0 = n_ld;
        push_px(640, 0, 1'b1, 1'b0);
        push_px(5, 480, 1'b0, 1'b1);
        drain();
        check("t3_writes", n_writes - w0, 0);
        check("t3_line_done_count", n_ld - l0, 1);
`ifdef PIXEL_WRITER_CLIP_COUNT_EN
        check("t3_clip_count", longint'(clip_count), 2);
`endif

        // Corners: (639,479) -> 307199, (0,0) -> 0
        w0 = n_writes;
        push_px(639, 479, 1'b1, 1'b0);
        push_px(0, 0, 1'b0, 1'b0);
        drain();
        check("t4_writes", n_writes - w0, 2);

        // Reset mid-write with 3 pixels queued
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) push_px(20 + i, 20, 1'b1, 1'b0);
        n = 0;
        while (!bus.mem_we && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_mem_we_before_reset", longint'(bus.mem_we), 1);
        w0 = n_writes;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("t5_mem_we_after_reset", longint'(bus.mem_we), 0);
        check("t5_busy_after_reset", longint'(busy), 0);
        check("t5_px_ready_after_reset", longint'(bus.px_ready), 1);
        bus.mem_ack = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_writes", n_writes - w0, 0);
        check("t5_busy_idle", longint'(busy), 0);

        // Streaming line (1,1)->(12,5) with mem_ack tied high
        do_reset();
        w0  = n_writes;
        l0  = n_ld;
        wc0 = write_cyc.size();
        for (int i = 0; i < 12; i++) push_px(i + 1, ys[i], bit'(i % 2), i == 11);
        drain();
        check("t6_writes", n_writes - w0, 12);
        if (write_cyc.size() >= wc0 + 12) begin
            for (int k = 1; k < 12; k++) begin
                check("t6_write_spacing", write_cyc[wc0 + k] - write_cyc[wc0 + k - 1], 3);
            end
            check("t6_line_done_after_last", ld_cyc - write_cyc[wc0 + 11], 1);
        end
        check("t6_line_done_count", n_ld - l0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
